// File: rtl/glyph_renderer.sv
// Two-stage pixel pipeline: maps screen coordinates into a digit glyph ROM and
// serializes the returned row bitmap to RGB332, with sync signals delayed to match.
module glyph_renderer #(
    parameter int          X0         = 320,
    parameter int          Y0         = 232,
    parameter int          SCALE_LOG2 = 0,
    parameter logic [7:0]  FG_COLOR   = 8'hFF,
    parameter logic [7:0]  BG_COLOR   = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pixEn,
    input  logic       videoOn,
    input  logic       hSyncIn,
    input  logic       vSyncIn,
    input  logic [9:0] hCount,
    input  logic [9:0] vCount,
    input  logic [1:0] digitSel,
    output logic [5:0] romAddr,
    input  logic [7:0] romData,
    output logic [7:0] rgbOut,
    output logic       hSyncOut,
    output logic       vSyncOut,
    output logic       frameActive
);

    // state      | meaning
    // WAIT_FRAME | after reset, pixels blanked until the first frame-start tick
    // RUN        | glyph drawn every frame until the next reset
    typedef enum logic {WAIT_FRAME, RUN} state_t;

    localparam logic [9:0] LP_X0 = 10'(X0);
    localparam logic [9:0] LP_X1 = 10'(X0 + (8 << SCALE_LOG2));
    localparam logic [9:0] LP_Y0 = 10'(Y0);
    localparam logic [9:0] LP_Y1 = 10'(Y0 + (16 << SCALE_LOG2));

    state_t     r_state;
    logic [1:0] r_digit;
    logic [2:0] r_col;
    logic       r_in_box;
    logic       r_video;
    logic       r_hsync1;
    logic       r_vsync1;

    logic       w_frame_start;
    logic       w_in_box;
    logic [9:0] w_dx;
    logic [9:0] w_dy;
    logic [3:0] w_row;
    logic [2:0] w_col;
    logic       w_bit;

    assign w_frame_start = (hCount == 10'd0) && (vCount == 10'd0);
    assign w_in_box      = (hCount >= LP_X0) && (hCount < LP_X1) &&
                           (vCount >= LP_Y0) && (vCount < LP_Y1);
    // Offsets wrap outside the box but are only consumed when w_in_box is set.
    assign w_dx  = hCount - LP_X0;
    assign w_dy  = vCount - LP_Y0;
    assign w_row = 4'(w_dy >> SCALE_LOG2);
    assign w_col = 3'(w_dx >> SCALE_LOG2);
    assign w_bit = romData[3'd7 - r_col];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= WAIT_FRAME;
            r_digit     <= 2'd0;
            r_col       <= 3'd0;
            r_in_box    <= 1'b0;
            r_video     <= 1'b0;
            r_hsync1    <= 1'b1;
            r_vsync1    <= 1'b1;
            romAddr     <= 6'd0;
            rgbOut      <= 8'd0;
            hSyncOut    <= 1'b1;
            vSyncOut    <= 1'b1;
            frameActive <= 1'b0;
        end else if (pixEn) begin
            case (r_state)
                WAIT_FRAME: begin
                    if (w_frame_start) begin
                        r_state     <= RUN;
                        frameActive <= 1'b1;
                    end
                end
                RUN: frameActive <= 1'b1;
                default: r_state <= WAIT_FRAME;
            endcase

            if (w_frame_start) r_digit <= digitSel;

            if (w_in_box) romAddr <= {r_digit, w_row};
            r_col    <= w_col;
            r_in_box <= w_in_box;
            r_video  <= videoOn;
            r_hsync1 <= hSyncIn;
            r_vsync1 <= vSyncIn;

            if (r_state != RUN || !r_video)
                rgbOut <= 8'd0;
            else
                rgbOut <= (r_in_box && w_bit) ? FG_COLOR : BG_COLOR;
            hSyncOut <= r_hsync1;
            vSyncOut <= r_vsync1;
        end
    end

endmodule

// File: tb/tb_glyph_renderer.sv
// Directed bench for glyph_renderer: unscaled and 2x instances share inputs,
// each backed by a small combinational ROM model.
module tb_glyph_renderer;

    logic       clk = 1'b0;
    logic       rst;
    logic       pixEn;
    logic       videoOn;
    logic       hSyncIn;
    logic       vSyncIn;
    logic [9:0] hCount;
    logic [9:0] vCount;
    logic [1:0] digitSel;

    logic [5:0] romAddr0, romAddr1;
    logic [7:0] romData0, romData1;
    logic [7:0] rgb0, rgb1;
    logic       hso0, hso1, vso0, vso1, fa0, fa1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_f(input logic [5:0] a);
        case (a)
            6'h00:   return 8'h0C;
            6'h1E:   return 8'hFF;
            default: return {2'b10, a};
        endcase
    endfunction

    assign romData0 = rom_f(romAddr0);
    assign romData1 = rom_f(romAddr1);

    glyph_renderer #(.X0(320), .Y0(232), .SCALE_LOG2(0)) dut0 (
        .clk(clk), .rst(rst), .pixEn(pixEn), .videoOn(videoOn),
        .hSyncIn(hSyncIn), .vSyncIn(vSyncIn), .hCount(hCount), .vCount(vCount),
        .digitSel(digitSel), .romAddr(romAddr0), .romData(romData0),
        .rgbOut(rgb0), .hSyncOut(hso0), .vSyncOut(vso0), .frameActive(fa0)
    );

    glyph_renderer #(.X0(320), .Y0(232), .SCALE_LOG2(1)) dut1 (
        .clk(clk), .rst(rst), .pixEn(pixEn), .videoOn(videoOn),
        .hSyncIn(hSyncIn), .vSyncIn(vSyncIn), .hCount(hCount), .vCount(vCount),
        .digitSel(digitSel), .romAddr(romAddr1), .romData(romData1),
        .rgbOut(rgb1), .hSyncOut(hso1), .vSyncOut(vso1), .frameActive(fa1)
    );

    typedef struct {
        logic [9:0] h;
        logic [9:0] v;
        logic       vid;
        logic [5:0] exp_addr;
        logic [7:0] exp_rgb;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input logic [9:0] h, input logic [9:0] v,
                        input logic vid, input logic hs, input logic vs);
        hCount  = h;
        vCount  = v;
        videoOn = vid;
        hSyncIn = hs;
        vSyncIn = vs;
        pixEn   = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // digit 0, unscaled, row 0 bitmap 0x0C
        vecs[0] = '{h: 10'd324, v: 10'd232, vid: 1'b1, exp_addr: 6'h00, exp_rgb: 8'hFF};
        vecs[1] = '{h: 10'd320, v: 10'd232, vid: 1'b1, exp_addr: 6'h00, exp_rgb: 8'h00};
        vecs[2] = '{h: 10'd325, v: 10'd232, vid: 1'b1, exp_addr: 6'h00, exp_rgb: 8'hFF};
        vecs[3] = '{h: 10'd324, v: 10'd232, vid: 1'b0, exp_addr: 6'h00, exp_rgb: 8'h00};
        vecs[4] = '{h: 10'd319, v: 10'd232, vid: 1'b1, exp_addr: 6'h00, exp_rgb: 8'h00};
        vecs[5] = '{h: 10'd324, v: 10'd248, vid: 1'b1, exp_addr: 6'h00, exp_rgb: 8'h00};

        rst = 1'b0; digitSel = 2'd2;
        tick(10'd324, 10'd232, 1'b1, 1'b0, 1'b0);
        tick(10'd324, 10'd232, 1'b1, 1'b0, 1'b0);
        chk("rst_addr", romAddr0, 6'h00);
        chk("rst_rgb", rgb0, 8'h00);
        chk("rst_hsync", hso0, 1'b1);
        chk("rst_vsync", vso0, 1'b1);
        chk("rst_active", fa0, 1'b0);

        rst = 1'b1;
        tick(10'd5, 10'd5, 1'b1, 1'b1, 1'b1);
        chk("wait_active", fa0, 1'b0);
        tick(10'd324, 10'd232, 1'b1, 1'b1, 1'b1);
        tick(10'd324, 10'd232, 1'b1, 1'b1, 1'b1);
        chk("wait_rgb_blank", rgb0, 8'h00);

        digitSel = 2'd0;
        tick(10'd0, 10'd0, 1'b1, 1'b1, 1'b1);
        chk("start_active", fa0, 1'b1);

        for (int i = 0; i < 6; i++) begin
            tick(vecs[i].h, vecs[i].v, vecs[i].vid, 1'b1, 1'b1);
            chk($sformatf("vec%0d_addr", i), romAddr0, vecs[i].exp_addr);
            tick(vecs[i].h, vecs[i].v, vecs[i].vid, 1'b1, 1'b1);
            chk($sformatf("vec%0d_rgb", i), rgb0, vecs[i].exp_rgb);
        end

        // digit 1, row 14 is solid: 8 lit pixels then background
        digitSel = 2'd1;
        tick(10'd0, 10'd0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick(10'(320 + i), 10'd246, 1'b1, 1'b1, 1'b1);
            if (i == 0) chk("stream_addr", romAddr0, 6'h1E);
            if (i >= 1) chk($sformatf("stream_rgb%0d", i - 1), rgb0, (i - 1 <= 7) ? 8'hFF : 8'h00);
        end
        tick(10'd319, 10'd246, 1'b1, 1'b1, 1'b1);
        tick(10'd319, 10'd246, 1'b1, 1'b1, 1'b1);
        chk("left_edge_bg", rgb0, 8'h00);

        tick(10'd100, 10'd100, 1'b1, 1'b1, 1'b1);
        tick(10'd100, 10'd100, 1'b1, 1'b0, 1'b1);
        chk("hs_n0", hso0, 1'b1);
        tick(10'd100, 10'd100, 1'b1, 1'b1, 1'b0);
        chk("hs_n1", hso0, 1'b0);
        chk("vs_n1", vso0, 1'b1);
        tick(10'd100, 10'd100, 1'b1, 1'b1, 1'b1);
        chk("hs_n2", hso0, 1'b1);
        chk("vs_n2", vso0, 1'b0);
        tick(10'd100, 10'd100, 1'b1, 1'b1, 1'b1);
        chk("vs_n3", vso0, 1'b1);

        // 2x instance: digit 1, vCount 234 is row 1 -> ROM 0x91
        tick(10'd328, 10'd234, 1'b1, 1'b1, 1'b1);
        chk("s1_addr", romAddr1, 6'h11);
        tick(10'd328, 10'd234, 1'b1, 1'b1, 1'b1);
        chk("s1_col4", rgb1, 8'h00);
        tick(10'd326, 10'd234, 1'b1, 1'b1, 1'b1);
        tick(10'd326, 10'd234, 1'b1, 1'b1, 1'b1);
        chk("s1_col3", rgb1, 8'hFF);
        tick(10'd322, 10'd234, 1'b1, 1'b1, 1'b1);
        tick(10'd322, 10'd234, 1'b1, 1'b1, 1'b1);
        chk("s1_col1", rgb1, 8'h00);

        tick(10'd320, 10'd246, 1'b1, 1'b1, 1'b1);
        tick(10'd320, 10'd246, 1'b1, 1'b1, 1'b1);
        pixEn = 1'b0; hCount = 10'd0; vCount = 10'd0; videoOn = 1'b0;
        hSyncIn = 1'b0; vSyncIn = 1'b0; digitSel = 2'd2;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("hold%0d_rgb", i), rgb0, 8'hFF);
            chk($sformatf("hold%0d_addr", i), romAddr0, 6'h1E);
            chk($sformatf("hold%0d_hs", i), hso0, 1'b1);
            chk($sformatf("hold%0d_vs", i), vso0, 1'b1);
        end
        tick(10'd320, 10'd246, 1'b1, 1'b1, 1'b1);
        chk("hold_resume_addr", romAddr0, 6'h1E);
        chk("hold_resume_rgb", rgb0, 8'hFF);

        digitSel = 2'd0;
        tick(10'd0, 10'd0, 1'b1, 1'b1, 1'b1);
        tick(10'd324, 10'd232, 1'b1, 1'b1, 1'b1);
        chk("dsel_before", romAddr0, 6'h00);
        digitSel = 2'd3;
        tick(10'd0, 10'd100, 1'b1, 1'b1, 1'b1);
        tick(10'd324, 10'd232, 1'b1, 1'b1, 1'b1);
        chk("dsel_midframe", romAddr0, 6'h00);
        tick(10'd0, 10'd0, 1'b1, 1'b1, 1'b1);
        tick(10'd324, 10'd232, 1'b1, 1'b1, 1'b1);
        chk("dsel_next_frame", romAddr0, 6'h30);

        // digit 3 row 8 -> ROM 0xB8, col 4 lit
        tick(10'd324, 10'd240, 1'b1, 1'b0, 1'b0);
        tick(10'd324, 10'd240, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_rgb", rgb0, 8'hFF);
        chk("pre_rst_addr", romAddr0, 6'h38);
        digitSel = 2'd1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk("mid_rst_addr", romAddr0, 6'h00);
        chk("mid_rst_rgb", rgb0, 8'h00);
        chk("mid_rst_hs", hso0, 1'b1);
        chk("mid_rst_vs", vso0, 1'b1);
        chk("mid_rst_active", fa0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(10'd324, 10'(241 + i), 1'b1, 1'b1, 1'b1);
            chk($sformatf("post_rst%0d_rgb", i), rgb0, 8'h00);
            chk($sformatf("post_rst%0d_active", i), fa0, 1'b0);
        end
        tick(10'd0, 10'd0, 1'b1, 1'b1, 1'b1);
        chk("resume_active", fa0, 1'b1);
        tick(10'd324, 10'd246, 1'b1, 1'b1, 1'b1);
        chk("resume_addr", romAddr0, 6'h1E);
        tick(10'd324, 10'd246, 1'b1, 1'b1, 1'b1);
        chk("resume_rgb", rgb0, 8'hFF);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/glyph_renderer.md
Name: glyph_renderer

Overview:
- Pixel-side consumer of the 64x8 digit glyph ROM (4 glyphs, digits 1-4, 16 rows x 8 columns, MSB = leftmost pixel).
- Sits between the VGA timing generator and the DAC/RGB pins. It turns the current pixel coordinates into ROM row addresses, reads back row bitmaps, and serializes them into an RGB pixel stream. It also delays the sync signals so they stay aligned with the pixels.
- Draws one selectable digit at a fixed screen position, with optional integer scaling.

Parameters:
X0, 320, left edge of the glyph box in pixels (10-bit)
Y0, 232, top edge of the glyph box in lines (10-bit)
SCALE_LOG2, 0, magnification 1<<SCALE_LOG2 (legal 0..2); X0+(8<<S) and Y0+(16<<S) must each be ≤ 1023
FG_COLOR, 8'hFF, RGB332 colour for set glyph bits
BG_COLOR, 8'h00, RGB332 colour for clear bits and outside the box during active video

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-low reset
pixEn  in  1  pixel-rate enable tick; the pipeline advances only when high
videoOn  in  1  active-video flag from the timing generator
hSyncIn  in  1  horizontal sync from the timing generator
vSyncIn  in  1  vertical sync from the timing generator
hCount  in  10  current pixel column
vCount  in  10  current line
digitSel  in  2  glyph to draw (0 = "1" ... 3 = "4")
romAddr  out  6  address to the glyph ROM, {digit, row}
romData  in  8  row bitmap returned combinationally by the ROM
rgbOut  out  8  RGB332 pixel
hSyncOut  out  1  hSyncIn delayed by 2 pixEn ticks
vSyncOut  out  1  vSyncIn delayed by 2 pixEn ticks
frameActive  out  1  high while FSM is in RUN

Behaviour:
- Reset (rst=0 sampled on a clk edge), and also mid-frame: romAddr=0, rgbOut=0, hSyncOut=1, vSyncOut=1, frameActive=0.
  - Reset also clears the latched digit to 0, clears all pipeline registers, and puts the FSM in WAIT_FRAME.
- When pixEn=0, all registers hold, including the FSM, the latched digit and the sync delays.
- FSM:
  - WAIT_FRAME -> RUN on a pixEn tick with hCount==0 && vCount==0.
  - RUN stays in RUN until reset.
  - In WAIT_FRAME, stage-2 rgbOut is forced to 0. Syncs are still delayed normally.
- Digit latch:
  - On each pixEn tick with hCount==0 && vCount==0, the latched digit takes digitSel. This includes the WAIT_FRAME -> RUN transition tick, and the value sampled is the one present on that tick.
  - digitSel changes mid-frame have no effect until the next frame start.
- Stage 1 (pixEn tick N):
  - inBox = (hCount ≥ X0) && (hCount < X0+(8<<S)) && (vCount ≥ Y0) && (vCount < Y0+(16<<S)). Compares are unsigned 10-bit. Subtraction results are used only when inBox=1, so no wrap-around artefacts occur.
  - row = ((vCount−Y0)>>S)[3:0] and col = ((hCount−X0)>>S)[2:0].
  - Register romAddr <= {digitLatched, row}, colR <= col, inBoxR, videoOnR, hSync1, vSync1.
  - When inBox=0, romAddr holds its previous value.
- Stage 2 (pixEn tick N+1):
  - Sample romData; bit = romData[7−colR].
  - rgbOut <= !run || !videoOnR ? 0 : (inBoxR && bit ? FG_COLOR : BG_COLOR).
  - hSyncOut <= hSync1, vSyncOut <= vSync1.
- Latency: a pixel presented on pixEn tick N appears on rgbOut after tick N+1, two pixEn ticks. Syncs carry identical latency.
- Timing: the ROM is combinational, so romAddr → romData must settle within one clk period. Stage 2 reads romData on the tick after romAddr was registered.
- frameActive = (state==RUN), registered.

Test Plan:
- Reset, then frame start, digitSel=0, S=0, vCount=232 (row 0, data 0x0C):
  - hCount=324 -> romAddr=0x00, rgbOut=0xFF two ticks later.
  - hCount=320 -> rgbOut=0x00.
- digitSel=1, vCount=246 (addr 0x1E, data 0xFF), hCount=320..327 -> eight consecutive rgbOut=0xFF.
  - hCount=328 -> rgbOut=BG (0x00).
  - hCount=319 -> BG.
- videoOn=0 inside the box -> rgbOut=0.
  - hSyncIn pulse low at tick N -> hSyncOut low at tick N+2 exactly.
- S=1: vCount=234, hCount=328 -> romAddr row=1, col=4.
  - pixEn held low 5 cycles mid-line -> all outputs frozen.
- digitSel changed 0->3 at vCount=100 -> romAddr[5:4] stays 0 until the next hCount=vCount=0 tick, then equals 3.
- rst=0 for one cycle at vCount=240 -> outputs at reset values, frameActive=0, rgbOut=0 through the rest of the frame.
  - RUN resumes at the next frame start.
